mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that responds on the CPU data bus: mem_write, data_adr, write_data and read_data.
- Sits beside dmem. The top level uses sel to steer read_data from either this block or dmem.
- The CPU writes bytes into a small TX FIFO. A baud-rate state machine serialises them on tx as 8N1, LSB first.
- Status and divisor registers are readable and writable through the same bus.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/mmio_uart_tx_sync_fifo.sv | 48 ++++
 rtl/mmio_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter states and the divisor clamp.
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // A bit period shorter than two clocks would not leave room for the reload.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART: write strobe, address and data in, combinational read data and select out.
interface mmio_uart_tx_if;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        sel;

  modport master (output mem_write, data_adr, write_data, input read_data, sel);
  modport slave  (input mem_write, data_adr, write_data, output read_data, sel);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry.
// A push while full is taken only if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; the pointers and count alone define the contents.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: three-word register window on the CPU
// data bus, a TX FIFO, and a baud-paced state machine driving a registered tx line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFFFF00,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic            clock,
  input  logic            reset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [29:0]   word_off;
  logic [3:0]    reg_off;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_divisor;
  logic [15:0]   divisor;
  logic [15:0]   reload;
  logic          overflow;
  logic [31:0]   status_word;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  tx_state_t     state, state_next;
  logic [15:0]   baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;

  logic          unused_bits;
  assign unused_bits = ^{bus.data_adr[1:0], bus.write_data[31:16]};

  // Offset 0xC lies in the aligned window but is not a register, so it is not selected.
  assign word_off   = bus.data_adr[31:2] - BASE_ADDR[31:2];
  assign bus.sel    = (word_off < 30'd3);
  assign reg_off    = {word_off[1:0], 2'b00};
  assign wr_txdata  = bus.mem_write && bus.sel && (reg_off == OFF_TXDATA);
  assign wr_status  = bus.mem_write && bus.sel && (reg_off == OFF_STATUS);
  assign wr_divisor = bus.mem_write && bus.sel && (reg_off == OFF_DIVISOR);

  // A divisor written on the same edge as a bit boundary already paces the next bit.
  assign reload = eff_div(wr_divisor ? bus.write_data[15:0] : divisor) - 16'd1;

  always_comb begin
    status_word                        = '0;
    status_word[ST_FULL]               = fifo_full;
    status_word[ST_EMPTY]              = fifo_empty;
    status_word[ST_BUSY]               = (state != IDLE);
    status_word[ST_OVERFLOW]           = overflow;
    status_word[ST_COUNT_LSB +: 4]     = 4'(fifo_count);
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.sel) begin
      case (reg_off)
        OFF_STATUS:  bus.read_data = status_word;
        OFF_DIVISOR: bus.read_data = {16'b0, divisor};
        default:     bus.read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divisor  <= 16'(CLKS_PER_BIT);
      overflow <= 1'b0;
    end else begin
      if (wr_divisor) divisor <= bus.write_data[15:0];
      if (wr_status)
        overflow <= 1'b0;
      else if (wr_txdata && fifo_full && !fifo_pop)
        overflow <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (bus.write_data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  // tx_next is the line level for the cycle after this edge, so tx is glitch-free.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          baud_next  = reload;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          state_next = DATA;
          bit_next   = '0;
          baud_next  = reload;
          tx_next    = shift[0];
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_next = reload;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = shift >> 1;
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            baud_next  = reload;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with a 4-clock baud divisor;
// expected line levels and register values are written out by hand.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFFFF00;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_UNM = BASE + 32'hC;

  logic        clock;
  logic        reset;
  logic        tx;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rv;

  int d4[10]   = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
  int d2[10]   = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
  int dmid[10] = '{4, 4, 4, 4, 4, 2, 2, 2, 2, 2};

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge and the task returns at the next negedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    bus_if.data_adr   = addr;
    bus_if.write_data = data;
    bus_if.mem_write  = 1'b1;
    @(negedge clock);
    bus_if.mem_write  = 1'b0;
    bus_if.write_data = '0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] value);
    bus_if.data_adr = addr;
    #1;
    value = bus_if.read_data;
  endtask

  // Samples tx once per cycle over a frame; samples before 'first' were already consumed by the caller.
  task automatic checkFrame(input logic [7:0] b, input int dur[10], input int first,
                            input int exp_count, input int wr_sample, input logic [31:0] wr_val);
    int          s;
    logic        exp_bit;
    logic [31:0] v;
    s = 0;
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      for (int c = 0; c < dur[bit_i]; c++) begin
        if (s >= first) begin
          @(negedge clock);
          bus_if.mem_write = 1'b0;
          if (bit_i == 0)      exp_bit = 1'b0;
          else if (bit_i == 9) exp_bit = 1'b1;
          else                 exp_bit = b[bit_i-1];
          checkOutput($sformatf("tx byte %02h bit %0d cyc %0d", b, bit_i, c), {31'b0, tx}, {31'b0, exp_bit});
          if (s == first) begin
            readReg(A_ST, v);
            checkOutput($sformatf("busy/count byte %02h", b), v & 32'hF04, 32'(exp_count << 8) | 32'h4);
          end
          if (s == wr_sample) begin
            bus_if.data_adr   = A_DIV;
            bus_if.write_data = wr_val;
            bus_if.mem_write  = 1'b1;
          end
        end
        s++;
      end
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus_if.mem_write  = 1'b0;
    bus_if.data_adr   = '0;
    bus_if.write_data = '0;
    #22 reset = 1'b0;
    @(negedge clock);

    // Reset state
    checkOutput("reset tx", {31'b0, tx}, 32'h1);
    readReg(A_ST, rv);  checkOutput("reset status", rv, 32'h2);
    readReg(A_DIV, rv); checkOutput("reset divisor", rv, 32'h4);
    readReg(A_TX, rv);  checkOutput("txdata reads 0", rv, 32'h0);
    checkOutput("sel txdata", {31'b0, bus_if.sel}, 32'h1);

    // Single frame 0x55
    applyStimulus(A_TX, 32'h55);
    checkOutput("tx high before pop", {31'b0, tx}, 32'h1);
    checkFrame(8'h55, d4, 0, 0, -1, 32'h0);
    @(negedge clock);
    readReg(A_ST, rv); checkOutput("status after 0x55", rv, 32'h2);

    // Back-to-back frames
    applyStimulus(A_TX, 32'hA3);
    applyStimulus(A_TX, 32'h0F);
    applyStimulus(A_TX, 32'hFF);
    checkOutput("b2b start bit", {31'b0, tx}, 32'h0);
    checkFrame(8'hA3, d4, 2, 2, -1, 32'h0);
    checkFrame(8'h0F, d4, 0, 1, -1, 32'h0);
    checkFrame(8'hFF, d4, 0, 0, -1, 32'h0);
    @(negedge clock);
    readReg(A_ST, rv); checkOutput("status after b2b", rv, 32'h2);

    // FIFO fill and overflow with a very slow line
    applyStimulus(A_DIV, 32'hFFFF);
    readReg(A_DIV, rv); checkOutput("divisor ffff", rv, 32'hFFFF);
    for (int i = 0; i < 9; i++) applyStimulus(A_TX, 32'(i));
    readReg(A_ST, rv); checkOutput("status full", rv, 32'h805);
    applyStimulus(A_TX, 32'h99);
    readReg(A_ST, rv); checkOutput("status overflow", rv, 32'h80D);
    applyStimulus(A_ST, 32'h0);
    readReg(A_ST, rv); checkOutput("overflow cleared", rv, 32'h805);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    readReg(A_ST, rv);  checkOutput("status after reset", rv, 32'h2);
    readReg(A_DIV, rv); checkOutput("divisor after reset", rv, 32'h4);

    // Divisor change mid-frame during data bit 3
    applyStimulus(A_TX, 32'h6B);
    checkFrame(8'h6B, dmid, 0, 0, 17, 32'h2);
    @(negedge clock);
    readReg(A_ST, rv);  checkOutput("status after mid change", rv, 32'h2);
    readReg(A_DIV, rv); checkOutput("divisor 2", rv, 32'h2);

    // Divisor 0 is clamped to 2
    applyStimulus(A_DIV, 32'h0);
    readReg(A_DIV, rv); checkOutput("divisor 0 raw", rv, 32'h0);
    applyStimulus(A_TX, 32'h96);
    checkFrame(8'h96, d2, 0, 0, -1, 32'h0);
    @(negedge clock);
    readReg(A_ST, rv); checkOutput("status after clamp", rv, 32'h2);

    // Reset during data bit 5 with three bytes queued
    applyStimulus(A_DIV, 32'h4);
    applyStimulus(A_TX, 32'hC3);
    applyStimulus(A_TX, 32'h11);
    applyStimulus(A_TX, 32'h22);
    applyStimulus(A_TX, 32'h33);
    readReg(A_ST, rv); checkOutput("three queued", rv & 32'hF04, 32'h304);
    repeat (23) @(negedge clock);
    checkOutput("tx bit5 low", {31'b0, tx}, 32'h0);
    #2 reset = 1'b1;
    #1 checkOutput("tx async reset", {31'b0, tx}, 32'h1);
    @(negedge clock);
    reset = 1'b0;
    readReg(A_ST, rv);  checkOutput("status after mid reset", rv, 32'h2);
    readReg(A_DIV, rv); checkOutput("divisor after mid reset", rv, 32'h4);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      checkOutput($sformatf("tx idle after reset %0d", i), {31'b0, tx}, 32'h1);
    end

    // Unmapped offset 0xC and an address just below the window
    readReg(A_UNM, rv);
    checkOutput("unmapped read_data", rv, 32'h0);
    checkOutput("unmapped sel", {31'b0, bus_if.sel}, 32'h0);
    readReg(BASE - 32'h4, rv);
    checkOutput("below window sel", {31'b0, bus_if.sel}, 32'h0);
    applyStimulus(A_UNM, 32'h1234);
    readReg(A_DIV, rv); checkOutput("divisor after 0xC write", rv, 32'h4);
    checkOutput("sel divisor", {31'b0, bus_if.sel}, 32'h1);
    readReg(A_ST, rv);  checkOutput("status after 0xC write", rv, 32'h2);
    checkOutput("tx after 0xC write", {31'b0, tx}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
